cpu_ctrl_seq: RTL and testbench
===============================

Name: cpu_ctrl_seq

Overview:
- Fetch/decode/execute sequencer for the accumulator CPU.
- Sits directly upstream of the datapath registers (PC, IR, MAR, AC), all instances of the shared inc/we/clr register, and drives their inc/we strobes, the internal-bus source select and the memory handshake.
- Consumes the IR contents and the AC zero flag.

Parameters:
- W, 8, instruction/data width.
- OPW, 3, opcode field width; opcode = ir[W-1:W-OPW].
- AW, W-OPW, operand/address field width; operand = ir[AW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset. One clock; async active-low reset, fixed.
- ir  in  W  instruction register contents.
- ac_zero  in  1  accumulator == 0.
- mem_ack  in  1  memory completes current read/write this cycle.
- mem_rd  out  1  memory read request, held until ack.
- mem_wr  out  1  memory write request, held until ack.
- bus_sel  out  2  bus source: 0=PC, 1=IR operand (zero-extended), 2=MEM, 3=AC.
- pc_inc  out  1  PC increment strobe.
- pc_we  out  1  PC load strobe.
- ir_we  out  1  IR load strobe.
- mar_we  out  1  MAR load strobe.
- ac_we  out  1  AC load strobe (from ALU result).
- alu_op  out  2  0=pass bus, 1=add, 2=sub.
- halted  out  1  CPU halted.

Behaviour:
- Opcodes: 000 NOP, 001 LDA, 010 STA, 011 ADD, 100 SUB, 101 JMP, 110 JZ, 111 HLT.
- States: FETCH_A, FETCH_M, DECODE, EXEC_A, EXEC_M, HALT. Reset state is FETCH_A.
- Outputs are combinational from state, ir and mem_ack (Mealy on ack). Every output not listed for a state is 0.
- While clr_n=0, all outputs are forced to 0, including halted.
- FETCH_A: bus_sel=0, mar_we=1 -> FETCH_M.
- FETCH_M: mem_rd=1, bus_sel=2.
  - ack=0: stay.
  - ack=1: ir_we=1, pc_inc=1 in the same cycle -> DECODE.
- DECODE by opcode:
  - NOP -> FETCH_A.
  - LDA/STA/ADD/SUB: bus_sel=1, mar_we=1 -> EXEC_A.
  - JMP: bus_sel=1, pc_we=1 -> FETCH_A.
  - JZ: bus_sel=1, pc_we=ac_zero -> FETCH_A.
  - HLT -> HALT.
- EXEC_A: no strobes -> EXEC_M. This is the one-cycle MAR settle.
- EXEC_M:
  - LDA/ADD/SUB: mem_rd=1, bus_sel=2, alu_op=0/1/2. On ack: ac_we=1.
  - STA: mem_wr=1, bus_sel=3.
  - ack=0: stay with requests held stable. ack=1 -> FETCH_A.
- HALT: halted=1, no strobes. Exit only via reset.
- Latencies with zero-wait memory (ack in first request cycle): NOP/JMP/JZ/HLT 3 cycles; LDA/STA/ADD/SUB 5 cycles. Each ack wait cycle adds one.
- Invariants:
  - pc_inc and pc_we never both 1.
  - mem_rd and mem_wr never both 1.
  - At most one of mar_we/ir_we/ac_we/pc_we per cycle.
- mem_ack outside FETCH_M/EXEC_M is ignored.
- ir is sampled only in DECODE/EXEC_M; its value in other states has no effect.
- Reset mid-operation (any state, including during a held request): outputs drop to 0 immediately; state = FETCH_A on release. The first post-release edge sees FETCH_A outputs.
- PC wrap-around is the PC register's concern; the sequencer only pulses pc_inc.
- Unused state encodings -> FETCH_A on the next edge.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_NOP..OP_HLT;
  - bus_sel constants BUS_PC/BUS_IR/BUS_MEM/BUS_AC;
  - alu_op constants ALU_PASS/ALU_ADD/ALU_SUB;
  - state encoding.
- One sub-module is natural: cpu_ctrl_decode, combinational, mapping (state, opcode, ac_zero, mem_ack) to the output strobe vector plus next state. The top holds only the state register with async clr_n.

Test Plan:
- Reset: clr_n=0 in EXEC_M with mem_rd high -> all outputs 0 immediately. Release -> mar_we=1, bus_sel=0 in the first cycle.
- LDA 0x05 (ir=0x25), ack every request cycle -> 5-cycle sequence: mar_we; mem_rd+ir_we+pc_inc; mar_we bus_sel=1; idle; mem_rd+ac_we alu_op=0.
- ADD with 3 wait cycles (ack low 3 cycles in EXEC_M) -> mem_rd held 4 cycles, ac_we=1 and alu_op=1 only in the ack cycle, total 8 cycles.
- JZ 0x1F (ir=0xDF): ac_zero=1 -> pc_we=1, bus_sel=1. ac_zero=0 -> pc_we=0. Both return to FETCH_A after 3 cycles.
- STA 0x0A (ir=0x4A) -> mem_wr=1, bus_sel=3 in EXEC_M; mem_rd=0 there; ac_we never asserted.
- HLT (ir=0xE0) -> halted=1 from cycle 4. mem_ack pulses and ir changes produce no strobes. clr_n pulse -> returns to fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, bus/ALU selects,
// sequencer state encoding and the control strobe bundle.
package cpu_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_NOP = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_LDA = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_STA = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_JMP = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_HLT = 3'b111;

  localparam logic [1:0] BUS_PC  = 2'd0;
  localparam logic [1:0] BUS_IR  = 2'd1;
  localparam logic [1:0] BUS_MEM = 2'd2;
  localparam logic [1:0] BUS_AC  = 2'd3;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;

  typedef enum logic [2:0] {
    FETCH_A = 3'd0,
    FETCH_M = 3'd1,
    DECODE  = 3'd2,
    EXEC_A  = 3'd3,
    EXEC_M  = 3'd4,
    HALT    = 3'd5
  } state_t;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] bus_sel;
    logic       pc_inc;
    logic       pc_we;
    logic       ir_we;
    logic       mar_we;
    logic       ac_we;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  // Opcodes that go through the MAR-address / memory-access execute phase.
  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic [1:0] alu_for(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational control decode: (state, opcode, ac_zero, mem_ack) -> strobes + next state.
// Mealy on mem_ack in FETCH_M/EXEC_M; opcode only matters in DECODE/EXEC_M.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  state_t                i_state,
  input  logic [OPCODE_W-1:0]   i_opcode,
  input  logic                  i_ac_zero,
  input  logic                  i_mem_ack,
  output ctrl_t                 o_ctrl,
  output state_t                o_next
);

  always_comb begin
    o_ctrl = '0;
    o_next = FETCH_A;
    case (i_state)
      FETCH_A: begin
        o_ctrl.bus_sel = BUS_PC;
        o_ctrl.mar_we  = 1'b1;
        o_next         = FETCH_M;
      end

      FETCH_M: begin
        o_ctrl.mem_rd  = 1'b1;
        o_ctrl.bus_sel = BUS_MEM;
        if (i_mem_ack) begin
          o_ctrl.ir_we  = 1'b1;
          o_ctrl.pc_inc = 1'b1;
          o_next        = DECODE;
        end else begin
          o_next = FETCH_M;
        end
      end

      DECODE: begin
        if (is_mem_op(i_opcode)) begin
          o_ctrl.bus_sel = BUS_IR;
          o_ctrl.mar_we  = 1'b1;
          o_next         = EXEC_A;
        end else begin
          case (i_opcode)
            OP_JMP: begin
              o_ctrl.bus_sel = BUS_IR;
              o_ctrl.pc_we   = 1'b1;
            end
            OP_JZ: begin
              o_ctrl.bus_sel = BUS_IR;
              o_ctrl.pc_we   = i_ac_zero;
            end
            OP_HLT:  o_next = HALT;
            default: o_next = FETCH_A;
          endcase
        end
      end

      EXEC_A: o_next = EXEC_M;

      EXEC_M: begin
        if (i_opcode == OP_STA) begin
          o_ctrl.mem_wr  = 1'b1;
          o_ctrl.bus_sel = BUS_AC;
        end else if (is_mem_op(i_opcode)) begin
          o_ctrl.mem_rd  = 1'b1;
          o_ctrl.bus_sel = BUS_MEM;
          o_ctrl.alu_op  = alu_for(i_opcode);
          o_ctrl.ac_we   = i_mem_ack;
        end
        // A non-memory opcode here has no pending request, so leave rather than wait for an ack.
        o_next = (i_mem_ack || !is_mem_op(i_opcode)) ? FETCH_A : EXEC_M;
      end

      HALT: begin
        o_ctrl.halted = 1'b1;
        o_next        = HALT;
      end

      default: o_next = FETCH_A;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Fetch/decode/execute sequencer: state register plus the combinational decode.
// Outputs are forced low while clr_n is asserted.
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int W   = 8,
  parameter int OPW = 3,
  parameter int AW  = W - OPW
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [W-1:0] ir,
  input  logic         ac_zero,
  input  logic         mem_ack,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [1:0]   bus_sel,
  output logic         pc_inc,
  output logic         pc_we,
  output logic         ir_we,
  output logic         mar_we,
  output logic         ac_we,
  output logic [1:0]   alu_op,
  output logic         halted
);

  state_t              r_state;
  state_t              w_next;
  ctrl_t               w_ctrl;
  ctrl_t               w_out;
  logic [OPW-1:0]      w_opcode;
  logic                w_unused_operand;

  assign w_opcode = ir[W-1:W-OPW];
  // The operand reaches the bus through the IR register itself, not through this block.
  assign w_unused_operand = ^ir[AW-1:0];

  cpu_ctrl_decode u_decode (
    .i_state   (r_state),
    .i_opcode  (w_opcode),
    .i_ac_zero (ac_zero),
    .i_mem_ack (mem_ack),
    .o_ctrl    (w_ctrl),
    .o_next    (w_next)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= FETCH_A;
    else        r_state <= w_next;
  end

  assign w_out   = clr_n ? w_ctrl : '0;
  assign mem_rd  = w_out.mem_rd;
  assign mem_wr  = w_out.mem_wr;
  assign bus_sel = w_out.bus_sel;
  assign pc_inc  = w_out.pc_inc;
  assign pc_we   = w_out.pc_we;
  assign ir_we   = w_out.ir_we;
  assign mar_we  = w_out.mar_we;
  assign ac_we   = w_out.ac_we;
  assign alu_op  = w_out.alu_op;
  assign halted  = w_out.halted;

  a_pc_excl:  assert property (@(posedge clk) disable iff (!clr_n) !(pc_inc && pc_we));
  a_mem_excl: assert property (@(posedge clk) disable iff (!clr_n) !(mem_rd && mem_wr));
  a_we_excl:  assert property (@(posedge clk) disable iff (!clr_n)
                               $onehot0({mar_we, ir_we, ac_we, pc_we}));

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: directed per-cycle vectors push expected
// strobes; a negedge monitor pops and compares.
module tb_cpu_ctrl_seq;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [7:0] ir;
  logic       ac_zero;
  logic       mem_ack;
  logic       mem_rd, mem_wr, pc_inc, pc_we, ir_we, mar_we, ac_we, halted;
  logic [1:0] bus_sel, alu_op;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  cpu_ctrl_seq dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .ir      (ir),
    .ac_zero (ac_zero),
    .mem_ack (mem_ack),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .bus_sel (bus_sel),
    .pc_inc  (pc_inc),
    .pc_we   (pc_we),
    .ir_we   (ir_we),
    .mar_we  (mar_we),
    .ac_we   (ac_we),
    .alu_op  (alu_op),
    .halted  (halted)
  );

  // Packing order: rd wr bus[1:0] inc pwe irwe marwe acwe alu[1:0] halt
  function automatic logic [11:0] e(input logic rd, input logic wr, input logic [1:0] bus,
                                    input logic inc, input logic pwe, input logic irwe,
                                    input logic marwe, input logic acwe,
                                    input logic [1:0] alu, input logic hlt);
    return {rd, wr, bus, inc, pwe, irwe, marwe, acwe, alu, hlt};
  endfunction

  localparam logic [11:0] Z     = 12'h000;
  localparam logic [11:0] FA    = 12'b0_0_00_0_0_0_1_0_00_0;
  localparam logic [11:0] FM_AK = 12'b1_0_10_1_0_1_0_0_00_0;
  localparam logic [11:0] FM_WT = 12'b1_0_10_0_0_0_0_0_00_0;
  localparam logic [11:0] DC_MA = 12'b0_0_01_0_0_0_1_0_00_0;
  localparam logic [11:0] HLTD  = 12'b0_0_00_0_0_0_0_0_00_1;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] exp_v, act_v;
      string       nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {mem_rd, mem_wr, bus_sel, pc_inc, pc_we, ir_we, mar_we, ac_we, alu_op, halted};
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got %b required %b (rd wr bus inc pwe irwe marwe acwe alu halt)",
                 nm, act_v, exp_v);
      end
    end
  end

  task automatic step(input logic [7:0] v_ir, input logic v_ack, input logic v_az,
                      input logic v_rn, input logic [11:0] v_exp, input string nm);
    ir      = v_ir;
    mem_ack = v_ack;
    ac_zero = v_az;
    clr_n   = v_rn;
    exp_q.push_back(v_exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n = 1'b0; ir = 8'h00; ac_zero = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    // Reset state: everything low, including halted.
    step(8'hE0, 1'b1, 1'b1, 1'b0, Z, "reset_hold0");
    step(8'hFF, 1'b1, 1'b1, 1'b0, Z, "reset_hold1");

    // LDA 0x05, zero-wait memory; ack driven high in the idle EXEC_A cycle too.
    step(8'h25, 1'b0, 1'b0, 1'b1, FA,    "lda_fetch_a");
    step(8'h25, 1'b1, 1'b0, 1'b1, FM_AK, "lda_fetch_m");
    step(8'h25, 1'b0, 1'b0, 1'b1, DC_MA, "lda_decode");
    step(8'h25, 1'b1, 1'b0, 1'b1, Z,     "lda_exec_a");
    step(8'h25, 1'b1, 1'b0, 1'b1, e(1,0,2'd2,0,0,0,0,1,2'd0,0), "lda_exec_m");

    // ADD with three wait cycles in EXEC_M.
    step(8'h65, 1'b0, 1'b0, 1'b1, FA,    "add_fetch_a");
    step(8'h65, 1'b1, 1'b0, 1'b1, FM_AK, "add_fetch_m");
    step(8'h65, 1'b0, 1'b0, 1'b1, DC_MA, "add_decode");
    step(8'h65, 1'b0, 1'b0, 1'b1, Z,     "add_exec_a");
    for (int i = 0; i < 3; i++)
      step(8'h65, 1'b0, 1'b0, 1'b1, e(1,0,2'd2,0,0,0,0,0,2'd1,0), "add_exec_m_wait");
    step(8'h65, 1'b1, 1'b0, 1'b1, e(1,0,2'd2,0,0,0,0,1,2'd1,0), "add_exec_m_ack");

    // JZ taken, then JZ not taken.
    step(8'hDF, 1'b0, 1'b1, 1'b1, FA,    "jz1_fetch_a");
    step(8'hDF, 1'b1, 1'b1, 1'b1, FM_AK, "jz1_fetch_m");
    step(8'hDF, 1'b0, 1'b1, 1'b1, e(0,0,2'd1,0,1,0,0,0,2'd0,0), "jz1_decode");
    step(8'hDF, 1'b0, 1'b0, 1'b1, FA,    "jz0_fetch_a");
    step(8'hDF, 1'b1, 1'b0, 1'b1, FM_AK, "jz0_fetch_m");
    step(8'hDF, 1'b0, 1'b0, 1'b1, e(0,0,2'd1,0,0,0,0,0,2'd0,0), "jz0_decode");

    // JMP, then NOP with one fetch wait cycle.
    step(8'hA3, 1'b0, 1'b0, 1'b1, FA,    "jmp_fetch_a");
    step(8'hA3, 1'b1, 1'b0, 1'b1, FM_AK, "jmp_fetch_m");
    step(8'hA3, 1'b0, 1'b0, 1'b1, e(0,0,2'd1,0,1,0,0,0,2'd0,0), "jmp_decode");
    step(8'h00, 1'b0, 1'b0, 1'b1, FA,    "nop_fetch_a");
    step(8'h00, 1'b0, 1'b0, 1'b1, FM_WT, "nop_fetch_wait");
    step(8'h00, 1'b1, 1'b0, 1'b1, FM_AK, "nop_fetch_m");
    step(8'h00, 1'b0, 1'b0, 1'b1, Z,     "nop_decode");

    // STA 0x0A with one write wait cycle.
    step(8'h4A, 1'b0, 1'b0, 1'b1, FA,    "sta_fetch_a");
    step(8'h4A, 1'b1, 1'b0, 1'b1, FM_AK, "sta_fetch_m");
    step(8'h4A, 1'b0, 1'b0, 1'b1, DC_MA, "sta_decode");
    step(8'h4A, 1'b0, 1'b0, 1'b1, Z,     "sta_exec_a");
    step(8'h4A, 1'b0, 1'b0, 1'b1, e(0,1,2'd3,0,0,0,0,0,2'd0,0), "sta_exec_m_wait");
    step(8'h4A, 1'b1, 1'b0, 1'b1, e(0,1,2'd3,0,0,0,0,0,2'd0,0), "sta_exec_m_ack");

    // SUB, zero-wait.
    step(8'h81, 1'b0, 1'b0, 1'b1, FA,    "sub_fetch_a");
    step(8'h81, 1'b1, 1'b0, 1'b1, FM_AK, "sub_fetch_m");
    step(8'h81, 1'b0, 1'b0, 1'b1, DC_MA, "sub_decode");
    step(8'h81, 1'b0, 1'b0, 1'b1, Z,     "sub_exec_a");
    step(8'h81, 1'b1, 1'b0, 1'b1, e(1,0,2'd2,0,0,0,0,1,2'd2,0), "sub_exec_m");

    // Reset while an LDA read is held in EXEC_M.
    step(8'h25, 1'b0, 1'b0, 1'b1, FA,    "rst_fetch_a");
    step(8'h25, 1'b1, 1'b0, 1'b1, FM_AK, "rst_fetch_m");
    step(8'h25, 1'b0, 1'b0, 1'b1, DC_MA, "rst_decode");
    step(8'h25, 1'b0, 1'b0, 1'b1, Z,     "rst_exec_a");
    step(8'h25, 1'b0, 1'b0, 1'b1, e(1,0,2'd2,0,0,0,0,0,2'd0,0), "rst_exec_m_held");
    step(8'h25, 1'b1, 1'b0, 1'b0, Z,     "rst_mid_exec_m");
    step(8'h25, 1'b0, 1'b0, 1'b1, FA,    "rst_release_fetch_a");
    step(8'h25, 1'b1, 1'b0, 1'b1, FM_AK, "rst_release_fetch_m");
    step(8'h00, 1'b0, 1'b0, 1'b1, Z,     "rst_release_decode");

    // HLT: halted from the 4th cycle; ack pulses and ir changes do nothing.
    step(8'hE0, 1'b0, 1'b0, 1'b1, FA,    "hlt_fetch_a");
    step(8'hE0, 1'b1, 1'b0, 1'b1, FM_AK, "hlt_fetch_m");
    step(8'hE0, 1'b0, 1'b0, 1'b1, Z,     "hlt_decode");
    step(8'hE0, 1'b0, 1'b0, 1'b1, HLTD,  "hlt_c4");
    step(8'h25, 1'b1, 1'b1, 1'b1, HLTD,  "hlt_ack_lda");
    step(8'hA3, 1'b1, 1'b1, 1'b1, HLTD,  "hlt_ack_jmp");
    step(8'h4A, 1'b0, 1'b0, 1'b1, HLTD,  "hlt_sta");
    step(8'hE0, 1'b0, 1'b0, 1'b0, Z,     "hlt_reset");
    step(8'h00, 1'b0, 1'b0, 1'b1, FA,    "hlt_exit_fetch_a");
    step(8'h00, 1'b1, 1'b0, 1'b1, FM_AK, "hlt_exit_fetch_m");
    step(8'h00, 1'b0, 1'b0, 1'b1, Z,     "hlt_exit_decode");
    step(8'h00, 1'b0, 1'b0, 1'b1, FA,    "hlt_exit_next_fetch");

    @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
